dcache_ctrl: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the pipeline MEM stage and data memory.
- Drives d_readM/d_writeM toward memory and pulses complete2 back to the hazard unit, which stalls the pipeline from request until complete2.
- Hits complete in one cycle. Misses and writes wait on the memory handshake.

---
 rtl/dcache_pkg.sv | 29 ++
 rtl/dcache_array.sv | 49 ++++
 rtl/dcache_ctrl.sv | 150 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-through data cache.
// Optional build macro used by dcache_ctrl: DCACHE_STATS_EN (read hit/miss counters).
package dcache_pkg;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int LINE_WORDS = 4;
  localparam int NUM_LINES  = 4;

  localparam int OFFSET_W = $clog2(LINE_WORDS);
  localparam int INDEX_W  = $clog2(NUM_LINES);
  localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP  = 2'd1,
    FILL  = 2'd2,
    WRITE = 2'd3
  } state_t;

  // One cache line, word 0 in the least significant bits.
  typedef logic [LINE_WORDS-1:0][DATA_W-1:0] line_t;

  // Select one word of a line by its word offset.
  function automatic logic [DATA_W-1:0] pick_word(input line_t l, input logic [OFFSET_W-1:0] off);
    return l[off];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage for the data cache. Reads are combinational on the
// selected index; writes are either a full-line fill or a single-word update.
// Valid bits clear asynchronously on reset; tag and data are left as-is since
// an invalid line is never consulted.
module dcache_array
  import dcache_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic [INDEX_W-1:0]  index,
  output logic                valid,
  output logic [TAG_W-1:0]    tag,
  output line_t               line,
  input  logic                fill_en,
  input  logic [TAG_W-1:0]    fill_tag,
  input  line_t               fill_line,
  input  logic                word_en,
  input  logic [OFFSET_W-1:0] word_off,
  input  logic [DATA_W-1:0]   word_data
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  line_t                data_q [NUM_LINES];

  assign valid = valid_q[index];
  assign tag   = tag_q[index];
  assign line  = data_q[index];

  // Valid bits: set on a line fill, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[index] <= 1'b1;
    end
  end

  // Tag and data: a fill replaces the whole line, a write hit patches one word.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[index]  <= fill_tag;
      data_q[index] <= fill_line;
    end else if (word_en) begin
      data_q[index][word_off] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Handshake: the CPU holds d_readC/d_writeC (plus address/data) until the
// one-cycle complete2 pulse and drops it in that same cycle; toward memory,
// d_readM/d_writeM stay high until the one-cycle mem_ack pulse.
// Optional build macro: DCACHE_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         d_readC,
  input  logic                         d_writeC,
  input  logic [ADDR_W-1:0]            address_c,
  input  logic [DATA_W-1:0]            wdata_c,
  output logic [DATA_W-1:0]            rdata_c,
  output logic                         complete2,
  output logic                         d_readM,
  output logic                         d_writeM,
  output logic [ADDR_W-1:0]            address_m,
  output logic [DATA_W-1:0]            wdata_m,
  input  logic [DATA_W*LINE_WORDS-1:0] line_m,
  input  logic                         mem_ack,
  output state_t                       state_dbg
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]                  hit_cnt,
  output logic [15:0]                  miss_cnt
`endif
);

  state_t              state;
  logic [ADDR_W-1:0]   req_addr;

  logic [OFFSET_W-1:0] cur_off;
  logic [INDEX_W-1:0]  cur_idx;
  logic [TAG_W-1:0]    cur_tag;
  logic [INDEX_W-1:0]  arr_idx;
  logic [OFFSET_W-1:0] req_off;

  logic                arr_valid;
  logic [TAG_W-1:0]    arr_tag;
  line_t               arr_line;
  line_t               fill_line;
  logic                hit;
  logic                rd_req;
  logic                fill_en;
  logic                word_en;

  assign cur_off   = address_c[OFFSET_W-1:0];
  assign cur_idx   = address_c[OFFSET_W +: INDEX_W];
  assign cur_tag   = address_c[ADDR_W-1 -: TAG_W];
  assign req_off   = req_addr[OFFSET_W-1:0];
  // While a fill is outstanding the array must point at the latched request.
  assign arr_idx   = (state == IDLE) ? cur_idx : req_addr[OFFSET_W +: INDEX_W];
  assign hit       = arr_valid && (arr_tag == cur_tag);
  // A simultaneous read and write is treated as a write.
  assign rd_req    = d_readC && !d_writeC;
  assign word_en   = (state == IDLE) && d_writeC && hit;
  assign fill_en   = (state == FILL) && mem_ack;
  assign fill_line = line_m;
  assign state_dbg = state;

  dcache_array u_array (
    .clk       (clk),
    .reset_n   (reset_n),
    .index     (arr_idx),
    .valid     (arr_valid),
    .tag       (arr_tag),
    .line      (arr_line),
    .fill_en   (fill_en),
    .fill_tag  (req_addr[ADDR_W-1 -: TAG_W]),
    .fill_line (fill_line),
    .word_en   (word_en),
    .word_off  (cur_off),
    .word_data (wdata_c)
  );

  // Request FSM with registered memory-side and CPU-side outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      req_addr  <= '0;
      rdata_c   <= '0;
      complete2 <= 1'b0;
      d_readM   <= 1'b0;
      d_writeM  <= 1'b0;
      address_m <= '0;
      wdata_m   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_writeC) begin
            state     <= WRITE;
            d_writeM  <= 1'b1;
            address_m <= address_c;
            wdata_m   <= wdata_c;
          end else if (d_readC) begin
            req_addr <= address_c;
            if (hit) begin
              rdata_c   <= pick_word(arr_line, cur_off);
              complete2 <= 1'b1;
              state     <= RESP;
            end else begin
              d_readM   <= 1'b1;
              address_m <= {address_c[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
              state     <= FILL;
            end
          end
        end
        RESP: begin
          complete2 <= 1'b0;
          state     <= IDLE;
        end
        FILL: begin
          if (mem_ack) begin
            d_readM   <= 1'b0;
            rdata_c   <= pick_word(fill_line, req_off);
            complete2 <= 1'b1;
            state     <= RESP;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            d_writeM  <= 1'b0;
            complete2 <= 1'b1;
            state     <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  // Saturating read hit/miss counters, counted when a read leaves IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == IDLE && rd_req) begin
      if (hit && hit_cnt != 16'hFFFF) begin
        hit_cnt <= hit_cnt + 16'd1;
      end else if (!hit && miss_cnt != 16'hFFFF) begin
        miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Testbench for dcache_ctrl: directed vector table, hand-written corner
// sequences (ignored mem_ack, reset mid-fill) and random traffic checked
// against a line-granular model of the cache plus a flat memory image.
module tb_dcache_ctrl;

  logic        clk;
  logic        reset_n;
  logic        d_readC;
  logic        d_writeC;
  logic [15:0] address_c;
  logic [15:0] wdata_c;
  logic [15:0] rdata_c;
  logic        complete2;
  logic        d_readM;
  logic        d_writeM;
  logic [15:0] address_m;
  logic [15:0] wdata_m;
  logic [63:0] line_m;
  logic        mem_ack;
  logic [1:0]  state_dbg;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  dcache_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .d_readC   (d_readC),
    .d_writeC  (d_writeC),
    .address_c (address_c),
    .wdata_c   (wdata_c),
    .rdata_c   (rdata_c),
    .complete2 (complete2),
    .d_readM   (d_readM),
    .d_writeM  (d_writeM),
    .address_m (address_m),
    .wdata_m   (wdata_m),
    .line_m    (line_m),
    .mem_ack   (mem_ack),
    .state_dbg (state_dbg)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- memory model (the memory the cache talks to) ----------------
  logic [15:0] mem     [65536];
  logic [15:0] ref_mem [65536];
  int          mem_lat  = 3;
  int          wait_cnt = 0;

  // Responds to d_readM/d_writeM after mem_lat cycles with a one-cycle mem_ack.
  initial begin
    mem_ack = 1'b0;
    line_m  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!reset_n) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (d_readM || d_writeM) begin
        wait_cnt++;
        if (wait_cnt >= mem_lat) begin
          wait_cnt = 0;
          if (d_writeM) begin
            mem[address_m] = wdata_m;
          end else begin
            for (int w = 0; w < 4; w++) line_m[w*16 +: 16] = mem[address_m + w];
          end
          mem_ack = 1'b1;
        end
      end
    end
  end

  // ---------------- reference model: cache contents as line base addresses ----------------
  bit          m_valid [4];
  logic [15:0] m_base  [4];
  int          m_hits   = 0;
  int          m_misses = 0;
  logic [15:0] exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  // Predict one CPU operation; writes are write-through and never allocate.
  task automatic model_step(input bit wr, input logic [15:0] a, input logic [15:0] d,
                            output bit miss, output logic [15:0] val);
    int          idx;
    logic [15:0] base;
    base = a & 16'hFFFC;
    idx  = (a / 4) % 4;
    miss = 1'b0;
    if (wr) begin
      ref_mem[a] = d;
      val = d;
    end else begin
      if (m_valid[idx] && m_base[idx] == base) begin
        m_hits++;
      end else begin
        miss = 1'b1;
        m_misses++;
        m_valid[idx] = 1'b1;
        m_base[idx]  = base;
      end
      val = ref_mem[a];
    end
  endtask

  // ---------------- CPU driver ----------------
  task automatic cpu_op(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] got_rd, output int cyc, output bit saw_rm,
                        output bit saw_wm, output logic [15:0] got_am, output logic [15:0] got_wm,
                        output bit done);
    @(negedge clk);
    d_readC   = rd;
    d_writeC  = wr;
    address_c = a;
    wdata_c   = d;
    cyc = 0; done = 0; saw_rm = 0; saw_wm = 0;
    got_am = '0; got_wm = '0; got_rd = '0;
    while (!done && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (d_readM && d_writeM) chk("mem_req_exclusive", 32'd1, 32'd0);
      if (d_readM)  begin saw_rm = 1; got_am = address_m; end
      if (d_writeM) begin saw_wm = 1; got_am = address_m; got_wm = wdata_m; end
      if (complete2) begin done = 1; got_rd = rdata_c; end
    end
    d_readC  = 1'b0;
    d_writeC = 1'b0;
    if (!done) chk("complete2_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    chk("complete2_single_pulse", {31'd0, complete2}, 32'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
    bit          exp_rm;   // expect a line fill
    logic [15:0] exp_am;   // expected address_m when memory is used
    logic [15:0] exp_val;  // read data, or write word sent to memory
  } vec_t;

  vec_t vecs[9];

  logic [15:0] got_rd, got_am, got_wm, last_rd, exp_val;
  int          cyc, exp_cyc;
  bit          saw_rm, saw_wm, done, exp_miss;

  initial begin
    vecs[0] = '{1, 0, 16'h0012, 16'h0000, 1, 16'h0010, 16'h3333}; // cold miss
    vecs[1] = '{1, 0, 16'h0013, 16'h0000, 0, 16'h0000, 16'h4444}; // hit same line
    vecs[2] = '{0, 1, 16'h0011, 16'hBEEF, 0, 16'h0011, 16'hBEEF}; // write hit
    vecs[3] = '{1, 0, 16'h0011, 16'h0000, 0, 16'h0000, 16'hBEEF}; // read back updated word
    vecs[4] = '{0, 1, 16'h0052, 16'h1234, 0, 16'h0052, 16'h1234}; // write miss, no allocate
    vecs[5] = '{1, 0, 16'h0012, 16'h0000, 0, 16'h0000, 16'h3333}; // still hits
    vecs[6] = '{1, 0, 16'h0052, 16'h0000, 1, 16'h0050, 16'h1234}; // conflict miss
    vecs[7] = '{1, 0, 16'h0012, 16'h0000, 1, 16'h0010, 16'h3333}; // evicted, misses again
    vecs[8] = '{1, 1, 16'h0031, 16'h7777, 0, 16'h0031, 16'h7777}; // read+write: write wins

    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) * 16'h0101 ^ 16'h5A5A;
    mem[16'h0010] = 16'h1111;
    mem[16'h0011] = 16'h2222;
    mem[16'h0012] = 16'h3333;
    mem[16'h0013] = 16'h4444;
    for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
    model_reset();
    last_rd = 16'h0000;

    // ---- reset ----
    reset_n   = 1'b0;
    d_readC   = 1'b0;
    d_writeC  = 1'b0;
    address_c = '0;
    wdata_c   = '0;
    #2;
    chk("rst_complete2", {31'd0, complete2}, 32'd0);
    chk("rst_d_readM",   {31'd0, d_readM},   32'd0);
    chk("rst_d_writeM",  {31'd0, d_writeM},  32'd0);
    chk("rst_rdata_c",   {16'd0, rdata_c},   32'd0);
    chk("rst_address_m", {16'd0, address_m}, 32'd0);
    chk("rst_wdata_m",   {16'd0, wdata_m},   32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // ---- directed table ----
    mem_lat = 3;
    for (int i = 0; i < 9; i++) begin
      bit is_wr;
      is_wr = vecs[i].wr;
      model_step(is_wr, vecs[i].addr, vecs[i].data, exp_miss, exp_val);
      cpu_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
             got_rd, cyc, saw_rm, saw_wm, got_am, got_wm, done);
      exp_cyc = (vecs[i].exp_rm || is_wr) ? mem_lat + 1 : 1;
      chk($sformatf("vec%0d_done", i),    {31'd0, done},   32'd1);
      chk($sformatf("vec%0d_cycles", i),  cyc,             exp_cyc);
      chk($sformatf("vec%0d_d_readM", i), {31'd0, saw_rm}, {31'd0, vecs[i].exp_rm});
      chk($sformatf("vec%0d_d_writeM", i), {31'd0, saw_wm}, {31'd0, is_wr});
      if (vecs[i].exp_rm || is_wr)
        chk($sformatf("vec%0d_address_m", i), {16'd0, got_am}, {16'd0, vecs[i].exp_am});
      if (is_wr) begin
        chk($sformatf("vec%0d_wdata_m", i), {16'd0, got_wm}, {16'd0, vecs[i].exp_val});
        chk($sformatf("vec%0d_rdata_hold", i), {16'd0, got_rd}, {16'd0, last_rd});
      end else begin
        chk($sformatf("vec%0d_rdata_c", i), {16'd0, got_rd}, {16'd0, vecs[i].exp_val});
        last_rd = vecs[i].exp_val;
      end
    end

    // ---- stray mem_ack in IDLE is ignored ----
    @(negedge clk);
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("stray_ack_complete2", {31'd0, complete2}, 32'd0);
    chk("stray_ack_d_readM",   {31'd0, d_readM},   32'd0);
    chk("stray_ack_d_writeM",  {31'd0, d_writeM},  32'd0);
    repeat (2) @(posedge clk);

    // ---- reset in the middle of a fill ----
    mem_lat = 10;
    @(negedge clk);
    d_readC   = 1'b1;
    address_c = 16'h0092;
    repeat (3) @(posedge clk);
    #1;
    chk("midfill_d_readM_high", {31'd0, d_readM}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midfill_rst_d_readM",   {31'd0, d_readM},   32'd0);
    chk("midfill_rst_complete2", {31'd0, complete2}, 32'd0);
    chk("midfill_rst_rdata_c",   {16'd0, rdata_c},   32'd0);
    chk("midfill_rst_address_m", {16'd0, address_m}, 32'd0);
    d_readC = 1'b0;
    model_reset();
    last_rd = 16'h0000;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    mem_lat = 3;
    model_step(1'b0, 16'h0012, 16'h0000, exp_miss, exp_val);
    cpu_op(1'b1, 1'b0, 16'h0012, 16'h0000, got_rd, cyc, saw_rm, saw_wm, got_am, got_wm, done);
    chk("post_rst_miss",      {31'd0, saw_rm}, {31'd0, exp_miss});
    chk("post_rst_address_m", {16'd0, got_am}, 32'h0010);
    chk("post_rst_rdata_c",   {16'd0, got_rd}, {16'd0, exp_val});
    last_rd = exp_val;

    // ---- random traffic against the model ----
    for (int n = 0; n < 200; n++) begin
      bit          wr;
      logic [15:0] a, d;
      wr      = ($urandom_range(0, 3) == 0);
      a       = 16'($urandom_range(0, 255));
      d       = 16'($urandom);
      mem_lat = $urandom_range(1, 4);
      model_step(wr, a, d, exp_miss, exp_val);
      exp_q.push_back(exp_val);
      cpu_op(!wr, wr, a, d, got_rd, cyc, saw_rm, saw_wm, got_am, got_wm, done);
      exp_val = exp_q.pop_front();
      exp_cyc = (exp_miss || wr) ? mem_lat + 1 : 1;
      chk("rnd_cycles",   cyc,             exp_cyc);
      chk("rnd_d_readM",  {31'd0, saw_rm}, {31'd0, exp_miss});
      chk("rnd_d_writeM", {31'd0, saw_wm}, {31'd0, wr});
      if (wr) begin
        chk("rnd_address_m_wr", {16'd0, got_am}, {16'd0, a});
        chk("rnd_wdata_m",      {16'd0, got_wm}, {16'd0, exp_val});
        chk("rnd_rdata_hold",   {16'd0, got_rd}, {16'd0, last_rd});
      end else begin
        if (exp_miss) chk("rnd_address_m_rd", {16'd0, got_am}, {16'd0, a & 16'hFFFC});
        chk("rnd_rdata_c", {16'd0, got_rd}, {16'd0, exp_val});
        last_rd = exp_val;
      end
    end

`ifdef DCACHE_STATS_EN
    chk("hit_cnt",  {16'd0, hit_cnt},  m_hits);
    chk("miss_cnt", {16'd0, miss_cnt}, m_misses);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
